// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: arbitrates exc/ex/bp PC redirects (clk, rst_, event inputs, fetch_ready -> redir_* outputs, flush_pending, bp_drop)
module fetch_redirect_ctrl #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              exc_flush_all,
  input  logic [ADDR_W-1:0] cp0_excaddr,
  input  logic              ex_bp_error,
  input  logic [ADDR_W-1:0] ex_new_target,
  input  logic              ex_delot_en,
  input  logic [ADDR_W-1:0] ex_delot_pc,
  input  logic              bp_pred_en,
  input  logic [ADDR_W-1:0] bp_pred_target,
  input  logic              bp_delot_en,
  input  logic [ADDR_W-1:0] bp_delot_pc,
  input  logic              fetch_ready,
  output logic              redir_valid,
  output logic [ADDR_W-1:0] redir_pc,
  output logic [1:0]        redir_delot,
  output logic [1:0]        redir_src,
  output logic              flush_pending,
  output logic              bp_drop
);
  typedef enum logic [1:0] {IDLE, ISSUE, TARGET} state_t;
  state_t st_q, st_d;
  logic [ADDR_W-1:0] pc_q, pc_d, tgt_q, tgt_d;
  logic [1:0] dl_q, dl_d, src_q, src_d;
  logic has_q, has_d, drop_d, busy;
  assign busy = st_q != IDLE;
  assign redir_valid = busy;
  assign redir_pc = pc_q;
  assign redir_delot = busy ? dl_q : 2'b00;
  assign redir_src = busy ? src_q : 2'b00;
  assign flush_pending = busy && src_q[1];
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      st_q <= IDLE;
      pc_q <= RESET_VECTOR;
      tgt_q <= '0;
      dl_q <= 2'b00;
      src_q <= 2'b00;
      has_q <= 1'b0;
      bp_drop <= 1'b0;
    end else begin
      st_q <= st_d;
      pc_q <= pc_d;
      tgt_q <= tgt_d;
      dl_q <= dl_d;
      src_q <= src_d;
      has_q <= has_d;
      bp_drop <= drop_d;
    end
  end
  always_comb begin
    st_d = st_q;
    pc_d = pc_q;
    tgt_d = tgt_q;
    dl_d = dl_q;
    src_d = src_q;
    has_d = has_q;
    // bp only wins when nothing else is asserted and no redirect is in flight
    drop_d = bp_pred_en && (exc_flush_all || ex_bp_error || busy);
    if (exc_flush_all) begin
      st_d = ISSUE;
      pc_d = cp0_excaddr;
      has_d = 1'b0;
      dl_d = 2'b00;
      src_d = 2'b11;
    end else if (ex_bp_error && redir_src != 2'b11) begin
      st_d = ISSUE;
      pc_d = ex_delot_en ? ex_delot_pc : ex_new_target;
      tgt_d = ex_new_target;
      has_d = ex_delot_en;
      dl_d = ex_delot_en ? 2'b10 : 2'b00;
      src_d = 2'b10;
    end else if (bp_pred_en && !busy) begin
      st_d = ISSUE;
      pc_d = bp_delot_en ? bp_delot_pc : bp_pred_target;
      tgt_d = bp_pred_target;
      has_d = bp_delot_en;
      dl_d = bp_delot_en ? 2'b01 : 2'b00;
      src_d = 2'b01;
    end else if (busy && fetch_ready) begin
      if (st_q == ISSUE && has_q) begin
        st_d = TARGET;
        pc_d = tgt_q;
        dl_d = 2'b00;
        has_d = 1'b0;
      end else begin
        st_d = IDLE;
      end
    end
  end
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb_fetch_redirect_ctrl: scoreboard bench for fetch_redirect_ctrl
module tb_fetch_redirect_ctrl;
  logic clk = 1'b0;
  logic rst_ = 1'b1;
  logic exc_flush_all = 1'b0, ex_bp_error = 1'b0, ex_delot_en = 1'b0;
  logic bp_pred_en = 1'b0, bp_delot_en = 1'b0, fetch_ready = 1'b0;
  logic [31:0] cp0_excaddr = 32'h8000_0180;
  logic [31:0] ex_new_target = '0, ex_delot_pc = '0, bp_pred_target = '0, bp_delot_pc = '0;
  logic redir_valid, flush_pending, bp_drop;
  logic [31:0] redir_pc;
  logic [1:0] redir_delot, redir_src;
  logic [38:0] obs;
  logic [38:0] q[$];
  int errors = 0;
  int checks = 0;
  assign obs = {redir_valid, redir_pc, redir_delot, redir_src, flush_pending, bp_drop};
  always #5 clk = ~clk;
  fetch_redirect_ctrl dut (
    .clk(clk), .rst_(rst_),
    .exc_flush_all(exc_flush_all), .cp0_excaddr(cp0_excaddr),
    .ex_bp_error(ex_bp_error), .ex_new_target(ex_new_target),
    .ex_delot_en(ex_delot_en), .ex_delot_pc(ex_delot_pc),
    .bp_pred_en(bp_pred_en), .bp_pred_target(bp_pred_target),
    .bp_delot_en(bp_delot_en), .bp_delot_pc(bp_delot_pc),
    .fetch_ready(fetch_ready),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_delot(redir_delot),
    .redir_src(redir_src), .flush_pending(flush_pending), .bp_drop(bp_drop)
  );
  task automatic drv(input logic [5:0] s);
    {exc_flush_all, ex_bp_error, ex_delot_en, bp_pred_en, bp_delot_en, fetch_ready} = s;
  endtask
  task automatic test_reset;
    logic [38:0] e;
    q.push_back({1'b0, 32'hBFC0_0000, 2'b00, 2'b00, 1'b0, 1'b0});
    rst_ = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    e = q.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset got=%h want=%h", obs, e); end
    @(negedge clk);
    rst_ = 1'b0;
  endtask
  task automatic test_ex_delay_slot;
    logic [5:0] st [3];
    logic [38:0] ex [3];
    logic [38:0] e;
    ex_delot_pc = 32'h8000_0104;
    ex_new_target = 32'h8000_2000;
    st = '{6'b011001, 6'b000001, 6'b000001};
    ex = '{{1'b1, 32'h8000_0104, 2'b10, 2'b10, 1'b1, 1'b0},
           {1'b1, 32'h8000_2000, 2'b00, 2'b10, 1'b1, 1'b0},
           {1'b0, 32'h8000_2000, 2'b00, 2'b00, 1'b0, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drv(st[i]); q.push_back(ex[i]);
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL ex_delay_slot c%0d got=%h want=%h", i, obs, e); end
    end
  endtask
  task automatic test_bp_stall;
    logic [5:0] st [5];
    logic [38:0] ex [5];
    logic [38:0] e;
    bp_pred_target = 32'h8000_0400;
    st = '{6'b000100, 6'b000000, 6'b000000, 6'b000000, 6'b000001};
    for (int i = 0; i < 4; i++) ex[i] = {1'b1, 32'h8000_0400, 2'b00, 2'b01, 1'b0, 1'b0};
    ex[4] = {1'b0, 32'h8000_0400, 2'b00, 2'b00, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); drv(st[i]); q.push_back(ex[i]);
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL bp_stall c%0d got=%h want=%h", i, obs, e); end
    end
  endtask
  task automatic test_exc_priority;
    logic [5:0] st [3];
    logic [38:0] ex [3];
    logic [38:0] e;
    st = '{6'b111101, 6'b000001, 6'b000001};
    ex = '{{1'b1, 32'h8000_0180, 2'b00, 2'b11, 1'b1, 1'b1},
           {1'b0, 32'h8000_0180, 2'b00, 2'b00, 1'b0, 1'b0},
           {1'b0, 32'h8000_0180, 2'b00, 2'b00, 1'b0, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drv(st[i]); q.push_back(ex[i]);
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL exc_priority c%0d got=%h want=%h", i, obs, e); end
    end
  endtask
  task automatic test_hold_preempt;
    logic [5:0] st [6];
    logic [38:0] ex [6];
    logic [38:0] e;
    ex_new_target = 32'h8000_3000;
    st = '{6'b010000, 6'b000100, 6'b000000, 6'b100000, 6'b011000, 6'b000001};
    ex = '{{1'b1, 32'h8000_3000, 2'b00, 2'b10, 1'b1, 1'b0},
           {1'b1, 32'h8000_3000, 2'b00, 2'b10, 1'b1, 1'b1},
           {1'b1, 32'h8000_3000, 2'b00, 2'b10, 1'b1, 1'b0},
           {1'b1, 32'h8000_0180, 2'b00, 2'b11, 1'b1, 1'b0},
           {1'b1, 32'h8000_0180, 2'b00, 2'b11, 1'b1, 1'b0},
           {1'b0, 32'h8000_0180, 2'b00, 2'b00, 1'b0, 1'b0}};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); drv(st[i]); q.push_back(ex[i]);
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL hold_preempt c%0d got=%h want=%h", i, obs, e); end
    end
  endtask
  task automatic test_back_to_back;
    logic [5:0] st [6];
    logic [38:0] ex [6];
    logic [38:0] e;
    bp_delot_pc = 32'h8000_0500;
    bp_pred_target = 32'h8000_0600;
    st = '{6'b000110, 6'b010001, 6'b000001, 6'b000101, 6'b000101, 6'b000000};
    ex = '{{1'b1, 32'h8000_0500, 2'b01, 2'b01, 1'b0, 1'b0},
           {1'b1, 32'h8000_3000, 2'b00, 2'b10, 1'b1, 1'b0},
           {1'b0, 32'h8000_3000, 2'b00, 2'b00, 1'b0, 1'b0},
           {1'b1, 32'h8000_0600, 2'b00, 2'b01, 1'b0, 1'b0},
           {1'b0, 32'h8000_0600, 2'b00, 2'b00, 1'b0, 1'b1},
           {1'b0, 32'h8000_0600, 2'b00, 2'b00, 1'b0, 1'b0}};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); drv(st[i]); q.push_back(ex[i]);
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL back_to_back c%0d got=%h want=%h", i, obs, e); end
    end
  endtask
  task automatic test_exc_on_accept;
    logic [5:0] st [3];
    logic [38:0] ex [3];
    logic [38:0] e;
    ex_delot_pc = 32'h8000_0104;
    ex_new_target = 32'h8000_2000;
    st = '{6'b011001, 6'b100001, 6'b000001};
    ex = '{{1'b1, 32'h8000_0104, 2'b10, 2'b10, 1'b1, 1'b0},
           {1'b1, 32'h8000_0180, 2'b00, 2'b11, 1'b1, 1'b0},
           {1'b0, 32'h8000_0180, 2'b00, 2'b00, 1'b0, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drv(st[i]); q.push_back(ex[i]);
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL exc_on_accept c%0d got=%h want=%h", i, obs, e); end
    end
  endtask
  task automatic test_reset_mid_target;
    logic [5:0] st [2];
    logic [38:0] ex [2];
    logic [38:0] e;
    st = '{6'b011001, 6'b000000};
    ex = '{{1'b1, 32'h8000_0104, 2'b10, 2'b10, 1'b1, 1'b0},
           {1'b1, 32'h8000_0104, 2'b10, 2'b10, 1'b1, 1'b0}};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); drv(st[i]); q.push_back(ex[i]);
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_mid_target c%0d got=%h want=%h", i, obs, e); end
    end
    @(negedge clk); drv(6'b000001);
    @(posedge clk); #1;
    checks++;
    if (obs !== {1'b1, 32'h8000_2000, 2'b00, 2'b10, 1'b1, 1'b0}) begin errors++; $display("FAIL reset_mid_target in_target got=%h", obs); end
    #2;
    rst_ = 1'b1;
    q.push_back({1'b0, 32'hBFC0_0000, 2'b00, 2'b00, 1'b0, 1'b0});
    #1;
    e = q.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_mid_target async got=%h want=%h", obs, e); end
    @(negedge clk);
    rst_ = 1'b0;
    drv(6'b000001);
    q.push_back({1'b0, 32'hBFC0_0000, 2'b00, 2'b00, 1'b0, 1'b0});
    @(posedge clk); #1;
    e = q.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_mid_target after got=%h want=%h", obs, e); end
  endtask
  initial begin
    test_reset();
    test_ex_delay_slot();
    test_bp_stall();
    test_exc_priority();
    test_hold_preempt();
    test_back_to_back();
    test_exc_on_accept();
    test_reset_mid_target();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
